// File: rtl/biriscv_divider_seq_if.sv
// Issue/writeback interface of the sequential divider.
// The master (issue stage) presents an instruction, its operands and its
// register indices. The slave (divider) returns a one-cycle writeback pulse
// carrying the result and the destination index. While the divider is
// working it raises busy_o, and the issue stage holds back further divide
// operations until it drops.
interface biriscv_divider_seq_if;
  logic        opcode_valid_i;
  logic [31:0] opcode_opcode_i;
  logic [31:0] opcode_pc_i;
  logic        opcode_invalid_i;
  logic [4:0]  opcode_rd_idx_i;
  logic [4:0]  opcode_ra_idx_i;
  logic [4:0]  opcode_rb_idx_i;
  logic [31:0] opcode_ra_operand_i;
  logic [31:0] opcode_rb_operand_i;
  logic        writeback_valid_o;
  logic [31:0] writeback_value_o;
  logic [4:0]  writeback_rd_idx_o;
  logic        busy_o;

  modport master (
    output opcode_valid_i, opcode_opcode_i, opcode_pc_i, opcode_invalid_i,
           opcode_rd_idx_i, opcode_ra_idx_i, opcode_rb_idx_i,
           opcode_ra_operand_i, opcode_rb_operand_i,
    input  writeback_valid_o, writeback_value_o, writeback_rd_idx_o, busy_o
  );

  modport slave (
    input  opcode_valid_i, opcode_opcode_i, opcode_pc_i, opcode_invalid_i,
           opcode_rd_idx_i, opcode_ra_idx_i, opcode_rb_idx_i,
           opcode_ra_operand_i, opcode_rb_operand_i,
    output writeback_valid_o, writeback_value_o, writeback_rd_idx_o, busy_o
  );
endinterface

// File: rtl/biriscv_divider_seq.sv
// Sequential RV32M divider. It handles DIV, DIVU, REM and REMU using a
// restoring radix-2 loop that retires one quotient bit per cycle.
//   clk_i, rst_i : clock, and an asynchronous active-high reset
//   div_if       : issue inputs (opcode, operands, rd index) and writeback
//                  outputs (valid pulse, value, rd index, busy)
// SPECIAL_FASTPATH=1 lets divide-by-zero and signed overflow finish in one
// cycle. With 0, those cases run the full 32 iterations. The result is the
// same either way; only the latency changes.
module biriscv_divider_seq #(
  parameter int SPECIAL_FASTPATH = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  biriscv_divider_seq_if.slave  div_if
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [5:0]  count_q;
  logic [31:0] divisor_q;
  logic [31:0] rem_q;
  logic [31:0] quot_q;
  logic [31:0] special_val_q;
  logic [4:0]  rd_q;
  logic        is_rem_q;
  logic        neg_quot_q;
  logic        neg_rem_q;
  logic        special_q;
  logic        wb_valid_q;
  logic [31:0] wb_value_q;
  logic [4:0]  wb_rd_q;

  // Decode
  logic [31:0] instr;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        is_div_op;
  logic        accept;
  logic        op_signed;
  logic        op_rem;
  logic        div_by_zero;
  logic        overflow;
  logic        special;
  logic [31:0] special_val;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  assign instr     = div_if.opcode_opcode_i;
  assign op_a      = div_if.opcode_ra_operand_i;
  assign op_b      = div_if.opcode_rb_operand_i;
  // funct3[2] set selects the divide/remainder half of the M-extension
  assign is_div_op = (instr[6:0] == 7'b0110011) && (instr[31:25] == 7'b0000001) && instr[14];
  assign accept    = div_if.opcode_valid_i && !div_if.opcode_invalid_i && is_div_op &&
                     (state_q == ST_IDLE);
  assign op_signed = !instr[12];
  assign op_rem    = instr[13];

  assign div_by_zero = (op_b == '0);
  assign overflow    = op_signed && (op_a == 32'h8000_0000) && (op_b == '1);
  assign special     = div_by_zero || overflow;
  assign special_val = div_by_zero ? (op_rem ? op_a : '1)
                                   : (op_rem ? '0   : 32'h8000_0000);
  assign abs_a = (op_signed && op_a[31]) ? -op_a : op_a;
  assign abs_b = (op_signed && op_b[31]) ? -op_b : op_b;

  // These inputs do not affect the result.
  logic unused_ok;
  assign unused_ok = ^{div_if.opcode_pc_i, div_if.opcode_ra_idx_i, div_if.opcode_rb_idx_i,
                       instr[24:15], instr[11:7]};

  // One restoring step. The shifted partial remainder can reach 33 bits,
  // so the borrow is taken from a 34-bit difference.
  logic [32:0] shifted;
  logic [33:0] diff;
  logic        no_borrow;
  logic [31:0] rem_step;
  logic [31:0] quot_step;
  logic [31:0] result;

  always_comb begin
    shifted   = {rem_q, quot_q[31]};
    diff      = {1'b0, shifted} - {2'b00, divisor_q};
    no_borrow = !diff[33];
    rem_step  = no_borrow ? diff[31:0] : shifted[31:0];
    quot_step = {quot_q[30:0], no_borrow};
    if (special_q)
      result = special_val_q;
    else if (is_rem_q)
      result = neg_rem_q ? -rem_step : rem_step;
    else
      result = neg_quot_q ? -quot_step : quot_step;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      divisor_q     <= '0;
      rem_q         <= '0;
      quot_q        <= '0;
      special_val_q <= '0;
      rd_q          <= '0;
      is_rem_q      <= 1'b0;
      neg_quot_q    <= 1'b0;
      neg_rem_q     <= 1'b0;
      special_q     <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_value_q    <= '0;
      wb_rd_q       <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            rd_q          <= div_if.opcode_rd_idx_i;
            is_rem_q      <= op_rem;
            neg_quot_q    <= op_signed && (op_a[31] ^ op_b[31]);
            neg_rem_q     <= op_signed && op_a[31];
            divisor_q     <= abs_b;
            rem_q         <= '0;
            quot_q        <= abs_a;
            count_q       <= '0;
            special_q     <= special;
            special_val_q <= special_val;
            if (special && (SPECIAL_FASTPATH != 0)) begin
              state_q    <= ST_DONE;
              wb_valid_q <= 1'b1;
              wb_value_q <= special_val;
              wb_rd_q    <= div_if.opcode_rd_idx_i;
            end else begin
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          rem_q   <= rem_step;
          quot_q  <= quot_step;
          count_q <= count_q + 6'd1;
          // The 32nd step loads the writeback registers directly, so that
          // the outputs are valid for the whole DONE cycle.
          if (count_q == 6'd31) begin
            state_q    <= ST_DONE;
            wb_valid_q <= 1'b1;
            wb_value_q <= result;
            wb_rd_q    <= rd_q;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign div_if.writeback_valid_o  = wb_valid_q;
  assign div_if.writeback_value_o  = wb_value_q;
  assign div_if.writeback_rd_idx_o = wb_rd_q;
  assign div_if.busy_o             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_biriscv_divider_seq.sv
// Self-checking bench for biriscv_divider_seq. Two instances, one with the
// fast path enabled and one without, receive identical stimulus.
module tb_biriscv_divider_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  biriscv_divider_seq_if if_fast ();
  biriscv_divider_seq_if if_slow ();

  biriscv_divider_seq #(.SPECIAL_FASTPATH(1)) dut_fast (
    .clk_i(clk), .rst_i(rst), .div_if(if_fast));
  biriscv_divider_seq #(.SPECIAL_FASTPATH(0)) dut_slow (
    .clk_i(clk), .rst_i(rst), .div_if(if_slow));

  assign if_slow.opcode_valid_i      = if_fast.opcode_valid_i;
  assign if_slow.opcode_opcode_i     = if_fast.opcode_opcode_i;
  assign if_slow.opcode_pc_i         = if_fast.opcode_pc_i;
  assign if_slow.opcode_invalid_i    = if_fast.opcode_invalid_i;
  assign if_slow.opcode_rd_idx_i     = if_fast.opcode_rd_idx_i;
  assign if_slow.opcode_ra_idx_i     = if_fast.opcode_ra_idx_i;
  assign if_slow.opcode_rb_idx_i     = if_fast.opcode_rb_idx_i;
  assign if_slow.opcode_ra_operand_i = if_fast.opcode_ra_operand_i;
  assign if_slow.opcode_rb_operand_i = if_fast.opcode_rb_operand_i;

  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  int n_checks = 0;
  int n_errs   = 0;
  logic [31:0] last_val = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: plain RISC-V M-extension arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (f3)
      F_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      F_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      F_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] enc(input logic [6:0] funct7, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] opc);
    logic [4:0] rs1, rs2;
    rs1 = 5'($urandom);
    rs2 = 5'($urandom);
    return {funct7, rs2, rs1, f3, rd, opc};
  endfunction

  task automatic drive(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic inv);
    if_fast.opcode_valid_i      = 1'b1;
    if_fast.opcode_opcode_i     = instr;
    if_fast.opcode_pc_i         = $urandom;
    if_fast.opcode_invalid_i    = inv;
    if_fast.opcode_rd_idx_i     = rd;
    if_fast.opcode_ra_idx_i     = 5'($urandom);
    if_fast.opcode_rb_idx_i     = 5'($urandom);
    if_fast.opcode_ra_operand_i = a;
    if_fast.opcode_rb_operand_i = b;
  endtask

  // Watches 40 cycles. Cycle 1 is the cycle right after the issue edge.
  // When inject_at is nonzero, a competing DIV is presented in that cycle.
  task automatic watch(input int inject_at,
                       output int first_f, output int first_s,
                       output int pulses_f, output int pulses_s,
                       output int busy_f, output int busy_s,
                       output logic [31:0] val_f, output logic [31:0] val_s,
                       output logic [4:0] rd_f, output logic [4:0] rd_s);
    first_f = 0; first_s = 0; pulses_f = 0; pulses_s = 0; busy_f = 0; busy_s = 0;
    val_f = '0; val_s = '0; rd_f = '0; rd_s = '0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (if_fast.writeback_valid_o === 1'b1) begin
        if (pulses_f == 0) begin
          first_f = cyc; val_f = if_fast.writeback_value_o; rd_f = if_fast.writeback_rd_idx_o;
        end
        pulses_f++;
      end
      if (if_slow.writeback_valid_o === 1'b1) begin
        if (pulses_s == 0) begin
          first_s = cyc; val_s = if_slow.writeback_value_o; rd_s = if_slow.writeback_rd_idx_o;
        end
        pulses_s++;
      end
      if (if_fast.busy_o === 1'b1) busy_f++;
      if (if_slow.busy_o === 1'b1) busy_s++;
      if (inject_at != 0 && cyc == inject_at)
        drive(enc(7'b0000001, F_DIVU, 5'd17, 7'b0110011), 32'd50, 32'd5, 5'd17, 1'b0);
      else
        if_fast.opcode_valid_i = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int inject_at);
    int ff, fs, pf, ps, bf, bs;
    logic [31:0] vf, vs, exp;
    logic [4:0] rf, rs;
    bit sp;
    exp = ref_result(f3, a, b);
    sp  = is_special(f3, a, b);
    @(negedge clk);
    drive(enc(7'b0000001, f3, rd, 7'b0110011), a, b, rd, 1'b0);
    @(posedge clk);
    #1;
    if_fast.opcode_valid_i = 1'b0;
    watch(inject_at, ff, fs, pf, ps, bf, bs, vf, vs, rf, rs);
    check_eq({tag, "/val_fast"}, vf, exp);
    check_eq({tag, "/val_slow"}, vs, exp);
    check_eq({tag, "/rd_fast"}, 32'(rf), 32'(rd));
    check_eq({tag, "/rd_slow"}, 32'(rs), 32'(rd));
    check_eq({tag, "/pulses_fast"}, pf, 1);
    check_eq({tag, "/pulses_slow"}, ps, 1);
    check_eq({tag, "/lat_fast"}, ff, sp ? 1 : 33);
    check_eq({tag, "/lat_slow"}, fs, 33);
    check_eq({tag, "/busy_fast"}, bf, sp ? 1 : 33);
    check_eq({tag, "/busy_slow"}, bs, 33);
    check_eq({tag, "/hold_fast"}, if_fast.writeback_value_o, exp);
    check_eq({tag, "/hold_slow"}, if_slow.writeback_value_o, exp);
    last_val = exp;
  endtask

  task automatic run_ignored(input string tag, input logic [31:0] instr, input logic inv);
    int ff, fs, pf, ps, bf, bs;
    logic [31:0] vf, vs;
    logic [4:0] rf, rs;
    @(negedge clk);
    drive(instr, 32'd100, 32'd7, 5'd9, inv);
    @(posedge clk);
    #1;
    if_fast.opcode_valid_i = 1'b0;
    if_fast.opcode_invalid_i = 1'b0;
    watch(0, ff, fs, pf, ps, bf, bs, vf, vs, rf, rs);
    check_eq({tag, "/pulses_fast"}, pf, 0);
    check_eq({tag, "/pulses_slow"}, ps, 0);
    check_eq({tag, "/busy_fast"}, bf, 0);
    check_eq({tag, "/busy_slow"}, bs, 0);
    check_eq({tag, "/hold_fast"}, if_fast.writeback_value_o, last_val);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "/valid_fast"}, 32'(if_fast.writeback_valid_o), 0);
    check_eq({tag, "/value_fast"}, if_fast.writeback_value_o, 0);
    check_eq({tag, "/rd_fast"}, 32'(if_fast.writeback_rd_idx_o), 0);
    check_eq({tag, "/busy_fast"}, 32'(if_fast.busy_o), 0);
    check_eq({tag, "/valid_slow"}, 32'(if_slow.writeback_valid_o), 0);
    check_eq({tag, "/value_slow"}, if_slow.writeback_value_o, 0);
    check_eq({tag, "/rd_slow"}, 32'(if_slow.writeback_rd_idx_o), 0);
    check_eq({tag, "/busy_slow"}, 32'(if_slow.busy_o), 0);
  endtask

  initial begin
    int ff, fs, pf, ps, bf, bs;
    logic [31:0] vf, vs, a, b;
    logic [4:0] rf, rs;
    logic [2:0] f3;
    rst = 1'b1;
    if_fast.opcode_valid_i = 1'b0;
    if_fast.opcode_opcode_i = '0;
    if_fast.opcode_pc_i = '0;
    if_fast.opcode_invalid_i = 1'b0;
    if_fast.opcode_rd_idx_i = '0;
    if_fast.opcode_ra_idx_i = '0;
    if_fast.opcode_rb_idx_i = '0;
    if_fast.opcode_ra_operand_i = '0;
    if_fast.opcode_rb_operand_i = '0;
    #23;
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed cases. The first op issues on the first edge after reset release.
    run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 5'd5, 5);
    run_op("remu_100_7", F_REMU, 32'd100, 32'd7, 5'd6, 0);
    run_op("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'd2, 5'd7, 0);
    run_op("rem_m7_2", F_REM, 32'hFFFF_FFF9, 32'd2, 5'd8, 0);
    run_op("div_7_m2", F_DIV, 32'd7, 32'hFFFF_FFFE, 5'd9, 0);
    run_op("rem_7_m2", F_REM, 32'd7, 32'hFFFF_FFFE, 5'd10, 0);
    run_op("div_by0", F_DIV, 32'h1234, 32'd0, 5'd11, 0);
    run_op("remu_by0", F_REMU, 32'h1234, 32'd0, 5'd12, 0);
    run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0);
    run_op("rem_ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0);

    run_ignored("mul", enc(7'b0000001, 3'b000, 5'd9, 7'b0110011), 1'b0);
    run_ignored("mulh", enc(7'b0000001, 3'b001, 5'd9, 7'b0110011), 1'b0);
    run_ignored("div_invalid", enc(7'b0000001, F_DIV, 5'd9, 7'b0110011), 1'b1);
    run_ignored("add_f7", enc(7'b0000000, F_DIV, 5'd9, 7'b0110011), 1'b0);

    // Reset in CALC cycle 10 aborts the operation.
    @(negedge clk);
    drive(enc(7'b0000001, F_DIVU, 5'd3, 7'b0110011), 32'd100, 32'd7, 5'd3, 1'b0);
    @(posedge clk);
    #1;
    if_fast.opcode_valid_i = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #12;
    check_outputs_zero("mid_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    watch(0, ff, fs, pf, ps, bf, bs, vf, vs, rf, rs);
    check_eq("post_reset/pulses_fast", pf, 0);
    check_eq("post_reset/pulses_slow", ps, 0);
    check_outputs_zero("post_reset");
    last_val = '0;
    run_op("divu_9_3", F_DIVU, 32'd9, 32'd3, 5'd4, 0);

    // Randomized operations, biased toward the boundary cases.
    for (int i = 0; i < 40; i++) begin
      f3 = {1'b1, 2'($urandom)};
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
        3: b = $urandom_range(1, 16) | (($urandom & 1) != 0 ? 32'hFFFF_FFF0 : 32'h0);
        default: ;
      endcase
      run_op($sformatf("rand%0d", i), f3, a, b, 5'($urandom), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/biriscv_divider_seq.md
BIRISCV_DIVIDER_SEQ -- requirements
Module: biriscv_divider_seq

Interface
REQ-001 Parameter: SPECIAL_FASTPATH, default 1, meaning 1 = divide-by-zero and signed-overflow results complete in 1 cycle; 0 = they take full iterative latency.
REQ-002 clk_i  in  1  clock, rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 opcode_valid_i  in  1  issue presents an instruction this cycle.
REQ-005 opcode_opcode_i  in  32  instruction word.
REQ-006 opcode_pc_i  in  32  instruction PC; unused internally.
REQ-007 opcode_invalid_i  in  1  instruction flagged illegal; never accepted.
REQ-008 opcode_rd_idx_i / opcode_ra_idx_i / opcode_rb_idx_i  in  5 each  register indices.
REQ-009 opcode_ra_operand_i  in  32  dividend.
REQ-010 opcode_rb_operand_i  in  32  divisor.
REQ-011 writeback_valid_o  out  1  one-cycle completion pulse.
REQ-012 writeback_value_o  out  32  quotient or remainder.
REQ-013 writeback_rd_idx_o  out  5  destination register of the completed op.
REQ-014 busy_o  out  1  high whenever state != IDLE; issue stalls M-ext div ops while high.

Function
REQ-015 Decode: accept only when opcode[6:0]=0110011, funct7=0000001, funct3 in {100 DIV, 101 DIVU, 110 REM, 111 REMU}, opcode_valid_i=1, opcode_invalid_i=0, state=IDLE.
REQ-016 Any other opcode, including MUL/MULH*, is ignored: no state change, no writeback.
REQ-017 opcode_valid_i while busy_o=1 is ignored; no queuing.
REQ-018 States: IDLE, CALC, DONE; unused encodings return to IDLE.
REQ-019 On acceptance: latch rd index, op type, sign flags, |dividend|, |divisor| (absolute value for DIV/REM, raw for DIVU/REMU); clear a 6-bit iteration counter.
REQ-020 IDLE->CALC on normal acceptance; IDLE->DONE directly on a special case when SPECIAL_FASTPATH=1.
REQ-021 CALC: one restoring radix-2 step per cycle (shift remainder:quotient left 1, trial-subtract divisor, set quotient LSB on no borrow); exactly 32 cycles, then ->DONE.
REQ-022 DONE: writeback_valid_o=1 for exactly that cycle, then ->IDLE; a new op is acceptable in the following IDLE cycle.
REQ-023 Latency: normal op, writeback_valid_o high in the 33rd cycle after the acceptance edge; fast-path special case, in the 1st cycle after it.
REQ-024 Signed fix-up: quotient negated iff operand signs differ; remainder takes dividend sign; two's complement, 32-bit wrap.
REQ-025 Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> dividend unchanged.
REQ-026 Signed overflow (0x80000000 / 0xFFFFFFFF, DIV/REM): DIV -> 0x80000000, REM -> 0.
REQ-027 Both special-case results are identical for either SPECIAL_FASTPATH value; only latency differs.
REQ-028 writeback_value_o and writeback_rd_idx_o are registered and hold their last values until the next DONE.
REQ-029 ra_idx, rb_idx and pc inputs have no functional effect.

Reset
REQ-030 Asynchronous reset forces state=IDLE, busy_o=0, writeback_valid_o=0, writeback_value_o=0, writeback_rd_idx_o=0, counter and datapath registers = 0.
REQ-031 Reset during CALC or DONE aborts the op; no writeback pulse is produced after reset release.
REQ-032 First acceptance is permitted on the first rising edge with rst_i low.

Verification
REQ-033 DIVU 100/7, rd=5 -> busy_o high 33 cycles; then a single pulse with value 14 and rd 5; REMU same operands -> 2.
REQ-034 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV 7 / 0xFFFFFFFE -> 0xFFFFFFFD; REM -> 1.
REQ-035 DIV 0x1234 / 0 -> 0xFFFFFFFF and REMU 0x1234 / 0 -> 0x1234, each 1 cycle after acceptance (SPECIAL_FASTPATH=1) and 33 cycles after (=0).
REQ-036 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-037 Assert rst_i at CALC cycle 10, release -> no pulse, all outputs 0; next DIVU 9/3 -> 3 at nominal latency.
REQ-038 MUL opcode, or a DIV opcode with opcode_invalid_i=1, or a second DIV issued while busy -> ignored; only the original op writes back.
